// File: rtl/round_timer_if.sv
// Signal bundle between the game FSM / tick generator side and the round timer.
// The master side drives the control pulses and the budget; the slave side is the timer.
interface round_timer_if;
    logic       Start;
    logic       Pause;
    logic       Answer;
    logic [6:0] LoadSecs;
    logic       HundredMS;
    logic       TickEnable;
    logic [6:0] Secs;
    logic [3:0] Tenths;
    logic       Running;
    logic       Warning;
    logic       TimeUp;
    logic       Done;

    modport master (
        output Start, Pause, Answer, LoadSecs, HundredMS,
        input  TickEnable, Secs, Tenths, Running, Warning, TimeUp, Done
    );

    modport slave (
        input  Start, Pause, Answer, LoadSecs, HundredMS,
        output TickEnable, Secs, Tenths, Running, Warning, TimeUp, Done
    );
endinterface

// File: rtl/round_timer_ctrl.sv
// Countdown controller for one game round. Loads a budget in whole seconds,
// counts 100 ms ticks down to 0.0 while running, and reports remaining time,
// a low-time warning, a timeout pulse and a round-finished level.
module round_timer_ctrl #(
    parameter int MAX_SECS    = 99,
    parameter int WARN_TENTHS = 50
) (
    input logic          Clock,
    input logic          Reset,
    round_timer_if.slave tmr
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        RUN    = 3'd1,
        PAUSE  = 3'd2,
        STOP   = 3'd3,
        EXPIRE = 3'd4
    } state_t;

    localparam logic [6:0]  MAX_SECS_W = 7'(MAX_SECS);
    localparam logic [10:0] WARN_W     = 11'(WARN_TENTHS);

    state_t      state;
    state_t      state_nxt;
    logic [6:0]  secs;
    logic [6:0]  secs_nxt;
    logic [3:0]  tenths;
    logic [3:0]  tenths_nxt;
    logic        timeup;
    logic        timeup_nxt;
    logic [10:0] remain;

    // Budget saturation: above MAX_SECS clamps down, and a zero budget becomes
    // one second so a started round always has something to count.
    function automatic logic [6:0] clamp_load(input logic [6:0] ld);
        logic [6:0] r;
        if (ld == 7'd0)
            r = 7'd1;
        else if (ld > MAX_SECS_W)
            r = MAX_SECS_W;
        else
            r = ld;
        return r;
    endfunction

    // Remaining time in tenths; 11 bits covers 99.9 s with headroom.
    function automatic logic [10:0] to_tenths(input logic [6:0] s, input logic [3:0] t);
        return (11'(s) * 11'd10) + 11'(t);
    endfunction

    // State register and timeout flag.
    always_ff @(posedge Clock) begin
        if (!Reset) begin
            state  <= IDLE;
            timeup <= 1'b0;
        end else begin
            state  <= state_nxt;
            timeup <= timeup_nxt;
        end
    end

    // Remaining-time registers.
    always_ff @(posedge Clock) begin
        if (!Reset) begin
            secs   <= 7'd0;
            tenths <= 4'd0;
        end else begin
            secs   <= secs_nxt;
            tenths <= tenths_nxt;
        end
    end

    // Next-state and next-count decode; Start overrides everything, then
    // Answer, then Pause, and a tick only counts when nothing else happened.
    always_comb begin
        state_nxt  = state;
        secs_nxt   = secs;
        tenths_nxt = tenths;
        timeup_nxt = 1'b0;

        if (tmr.Start) begin
            state_nxt  = RUN;
            secs_nxt   = clamp_load(tmr.LoadSecs);
            tenths_nxt = 4'd0;
        end else begin
            case (state)
                RUN: begin
                    if (tmr.Answer) begin
                        state_nxt = STOP;
                    end else if (tmr.Pause) begin
                        state_nxt = PAUSE;
                    end else if (tmr.HundredMS) begin
                        // The zero check comes before any borrow so secs can
                        // never wrap below zero.
                        if (secs == 7'd0 && tenths <= 4'd1) begin
                            state_nxt  = EXPIRE;
                            secs_nxt   = 7'd0;
                            tenths_nxt = 4'd0;
                            timeup_nxt = 1'b1;
                        end else if (tenths != 4'd0) begin
                            tenths_nxt = tenths - 4'd1;
                        end else begin
                            tenths_nxt = 4'd9;
                            secs_nxt   = secs - 7'd1;
                        end
                    end
                end
                PAUSE: begin
                    if (tmr.Answer)
                        state_nxt = STOP;
                    else if (tmr.Pause)
                        state_nxt = RUN;
                end
                default: begin
                    // IDLE, STOP and EXPIRE hold until the next Start.
                end
            endcase
        end
    end

    // Output decode straight from the registers, so TickEnable follows the
    // state register and a late generator tick after leaving RUN is ignored.
    always_comb begin
        remain          = to_tenths(secs, tenths);
        tmr.TickEnable  = (state == RUN);
        tmr.Running     = (state == RUN) || (state == PAUSE);
        tmr.Done        = (state == STOP) || (state == EXPIRE);
        tmr.Warning     = tmr.Running && (remain <= WARN_W);
        tmr.TimeUp      = timeup;
        tmr.Secs        = secs;
        tmr.Tenths      = tenths;
    end

endmodule
